// File: rtl/led_matrix_scan_pwm.sv
// LED matrix column scanner with per-pixel PWM brightness, anti-ghosting
// blanking between columns and a double-buffered frame store.
module led_matrix_scan_pwm #(
    parameter int NCOLS          = 4,
    parameter int NROWS          = 8,
    parameter int PWM_BITS       = 4,
    parameter int PRESCALE       = 64,
    parameter int BLANK_CYCLES   = 16,
    parameter int LED_ACTIVE_LOW = 0,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                       clk12MHz,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [$clog2(NCOLS)-1:0]   wr_col,
    input  logic [$clog2(NROWS)-1:0]   wr_row,
    input  logic [PWM_BITS-1:0]        wr_level,
    input  logic                       swap_req,
    output logic                       swap_ack,
    output logic                       frame_start,
    output logic [NROWS-1:0]           leds,
    output logic [NCOLS-1:0]           lcol
);

    localparam int CW      = $clog2(NCOLS);
    localparam int SLOTS   = (2 ** PWM_BITS) - 1;
    localparam int CNT_MAX = ((BLANK_CYCLES > PRESCALE) ? BLANK_CYCLES : PRESCALE) - 1;
    localparam int CNTW    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [NCOLS-1:0] COL_OFF = {NCOLS{COL_ACTIVE_LOW != 0}};
    localparam logic [NROWS-1:0] LED_OFF = {NROWS{LED_ACTIVE_LOW != 0}};

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       col, col_n;
    logic [CNTW-1:0]     cnt, cnt_n;
    logic [PWM_BITS-1:0] slot, slot_n;
    logic                fs_n;
    logic                front_sel, front_sel_n;
    logic                pending;
    logic                swap_now;
    logic                wr_ok;
    logic [NCOLS-1:0]    col_hot;
    logic [NROWS-1:0]    row_on;

    logic [PWM_BITS-1:0] frame_buf [2][NCOLS][NROWS];

    // The swap is decided in the boundary cycle itself so a request arriving
    // in that very cycle still takes effect on the closing edge.
    assign swap_now    = frame_start & (pending | swap_req);
    assign swap_ack    = swap_now;
    assign front_sel_n = front_sel ^ swap_now;
    assign wr_ok       = wr_en && (int'(wr_col) < NCOLS) && (int'(wr_row) < NROWS);

    // Next-state logic for the blank/on column sequencer and PWM slot counter.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n = state;
        col_n   = col;
        cnt_n   = cnt;
        slot_n  = slot;
        fs_n    = 1'b0;
        case (state)
            ST_BLANK: begin
                if (int'(cnt) == BLANK_CYCLES - 1) begin
                    state_n = ST_ON;
                    cnt_n   = '0;
                    slot_n  = '0;
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            ST_ON: begin
                if (int'(cnt) == PRESCALE - 1) begin
                    cnt_n = '0;
                    if (int'(slot) == SLOTS - 1) begin
                        state_n = ST_BLANK;
                        slot_n  = '0;
                        if (int'(col) == NCOLS - 1) begin
                            col_n = '0;
                            fs_n  = 1'b1;
                        end else begin
                            col_n = col + CW'(1);
                        end
                    end else begin
                        slot_n = slot + PWM_BITS'(1);
                    end
                end else begin
                    cnt_n = cnt + CNTW'(1);
                end
            end
            default: state_n = ST_BLANK;
        endcase
    end

    // Row pattern for the next cycle; a write landing in the buffer that is
    // about to become front is forwarded so it shows without a cycle of lag.
    always_comb begin
        logic [PWM_BITS-1:0] lvl;
        col_hot = NCOLS'(1) << col_n;
        row_on  = '0;
        for (int r = 0; r < NROWS; r++) begin
            lvl = frame_buf[front_sel_n][col_n][r];
            if (swap_now && wr_ok && (wr_col == col_n) && (int'(wr_row) == r)) begin
                lvl = wr_level;
            end
            row_on[r] = (lvl > slot_n);
        end
    end

    // Sequencer state, swap bookkeeping and registered pin drive.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_BLANK;
            col         <= '0;
            cnt         <= '0;
            slot        <= '0;
            frame_start <= 1'b0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            lcol        <= COL_OFF;
            leds        <= LED_OFF;
        end else begin
            state       <= state_n;
            col         <= col_n;
            cnt         <= cnt_n;
            slot        <= slot_n;
            frame_start <= fs_n;
            front_sel   <= front_sel_n;
            pending     <= ~swap_now & (pending | swap_req);
            lcol        <= (state_n == ST_ON) ? (col_hot ^ COL_OFF) : COL_OFF;
            leds        <= (state_n == ST_ON) ? (row_on ^ LED_OFF) : LED_OFF;
        end
    end

    // Pixel writes always land in the buffer that is back before the edge.
    // NOTE: the frame store is flops with async clear because a blank frame must show right after reset.
    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < NCOLS; c++) begin
                    for (int r = 0; r < NROWS; r++) begin
                        frame_buf[b][c][r] <= '0;
                    end
                end
            end
        end else if (wr_ok) begin
            frame_buf[~front_sel][wr_col][wr_row] <= wr_level;
        end
    end

endmodule
